// File: rtl/aes_sched_if.sv
// Bundle of requester and core signals around the AES scheduler.
// The clients and the core model use the master modport. The scheduler uses the slave modport.
interface aes_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 128
);
  logic [NREQ-1:0]    req_valid;
  logic [2*NREQ-1:0]  req_func;
  logic [DW*NREQ-1:0] req_key;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               core_enable;
  logic [1:0]         core_func;
  logic [DW-1:0]      core_data;
  logic               core_ready;
  logic [DW-1:0]      core_result;

  modport master (
    output req_valid, req_func, req_key, req_data, core_ready, core_result,
    input  req_ready, rsp_valid, rsp_data, rsp_err, core_enable, core_func, core_data
  );

  modport slave (
    input  req_valid, req_func, req_key, req_data, core_ready, core_result,
    output req_ready, rsp_valid, rsp_data, rsp_err, core_enable, core_func, core_data
  );
endinterface

// File: rtl/aes_sched.sv
// Round-robin scheduler that shares one AES core among NREQ requesters.
// It keeps the last expanded key. A cipher or icipher request with a different key
// gets a key expansion first.
// Each state's actions appear on the registered outputs in the cycle after that state.
module aes_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 128
) (
  input  logic         clk,
  input  logic         rst,
  aes_sched_if.slave   bus,
  output logic         busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    KISSUE,
    KWAIT,
    DISSUE,
    DWAIT,
    RESP
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   grant_idx;
  logic            grant_found;
  logic [NREQ-1:0] grant_onehot;
  logic [NREQ-1:0] owner_onehot;
  logic [1:0]      func_reg;
  logic [DW-1:0]   key_cap;
  logic [DW-1:0]   data_cap;
  logic [DW-1:0]   key_reg;
  logic            key_valid;
  logic            key_hit;
  logic [DW-1:0]   res_reg;

  assign key_hit      = key_valid && (key_reg == key_cap);
  assign grant_onehot = NREQ'(1) << grant_idx;
  assign owner_onehot = NREQ'(1) << gidx;

  // Round-robin search that starts one past the last grant and wraps around.
  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    sel         = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(rr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IW'(idx);
      if (!grant_found && bus.req_valid[sel]) begin
        grant_found = 1'b1;
        grant_idx   = sel;
      end
    end
  end

  // Next-state logic for the request sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (grant_found) state_nxt = CHECK;
      CHECK: begin
        if (func_reg == 2'd0)      state_nxt = RESP;
        else if (func_reg == 2'd1) state_nxt = KISSUE;
        else if (key_hit)          state_nxt = DISSUE;
        else                       state_nxt = KISSUE;
      end
      KISSUE: state_nxt = KWAIT;
      KWAIT:  if (bus.core_ready) state_nxt = (func_reg == 2'd1) ? RESP : DISSUE;
      DISSUE: state_nxt = DWAIT;
      DWAIT:  if (bus.core_ready) state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Request capture, round-robin pointer, key cache and result holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr        <= IW'(NREQ - 1);
      gidx      <= '0;
      func_reg  <= 2'd0;
      key_cap   <= '0;
      data_cap  <= '0;
      key_reg   <= '0;
      key_valid <= 1'b0;
      res_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            rr       <= grant_idx;
            gidx     <= grant_idx;
            func_reg <= bus.req_func[int'(grant_idx)*2 +: 2];
            key_cap  <= bus.req_key[int'(grant_idx)*DW +: DW];
            data_cap <= bus.req_data[int'(grant_idx)*DW +: DW];
          end
        end
        KWAIT: begin
          if (bus.core_ready) begin
            key_reg   <= key_cap;
            key_valid <= 1'b1;
          end
        end
        DWAIT: begin
          if (bus.core_ready) res_reg <= bus.core_result;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs. Pulses last one cycle, and core_data/core_func/rsp_data hold between uses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.req_ready   <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_data    <= '0;
      bus.rsp_err     <= 1'b0;
      bus.core_enable <= 1'b0;
      bus.core_func   <= 2'd0;
      bus.core_data   <= '0;
      busy            <= 1'b0;
    end else begin
      bus.req_ready   <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.core_enable <= 1'b0;
      busy            <= (state_nxt != IDLE);
      case (state)
        IDLE: if (grant_found) bus.req_ready <= grant_onehot;
        KISSUE: begin
          bus.core_enable <= 1'b1;
          bus.core_func   <= 2'd1;
          bus.core_data   <= key_cap;
        end
        DISSUE: begin
          bus.core_enable <= 1'b1;
          bus.core_func   <= func_reg;
          bus.core_data   <= data_cap;
        end
        RESP: begin
          bus.rsp_valid <= owner_onehot;
          bus.rsp_err   <= (func_reg == 2'd0);
          bus.rsp_data  <= (func_reg[1]) ? res_reg : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sched.sv
// Scoreboard bench for aes_sched. It uses a behavioural AES core that only knows the
// FIPS-197 AES-128 example vector.
module tb_aes_sched;

  localparam int NREQ = 4;
  localparam int DW   = 128;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    int           port;
    logic [127:0] data;
    logic         err;
    int           lat;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;

  aes_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

  aes_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  logic          p_valid [NREQ];
  logic [1:0]    p_func  [NREQ];
  logic [DW-1:0] p_key   [NREQ];
  logic [DW-1:0] p_data  [NREQ];

  for (genvar p = 0; p < NREQ; p++) begin : g_pack
    assign bus.req_valid[p]          = p_valid[p];
    assign bus.req_func[2*p +: 2]    = p_func[p];
    assign bus.req_key[DW*p +: DW]   = p_key[p];
    assign bus.req_data[DW*p +: DW]  = p_data[p];
  end

  exp_t         sb_q[$];
  int           gnt_q[$];
  logic [129:0] core_log[$];
  int           checks;
  int           passes;
  int           cyc;
  int           core_lat;
  int           outstanding;
  int           grant_cycle [NREQ];

  // Free-running clock and cycle counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [129:0] act, input logic [129:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic queueExpect(input int port, input logic [127:0] data, input logic err, input int lat);
    exp_t e;
    e.port = port;
    e.data = data;
    e.err  = err;
    e.lat  = lat;
    gnt_q.push_back(port);
    sb_q.push_back(e);
  endtask

  function automatic logic [127:0] coreCompute(input logic [1:0] f, input logic [127:0] d,
                                                input logic [127:0] ek, input logic ekv);
    logic [127:0] r;
    r = ~d;
    if (f == 2'd1) r = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
    else if (f == 2'd2 && ekv && ek == KEY && d == PT) r = CT;
    else if (f == 2'd3 && ekv && ek == KEY && d == CT) r = PT;
    return r;
  endfunction

  // Behavioural core. It completes core_lat cycles after each enable and forgets its key on reset.
  task automatic coreLoop();
    int           cnt;
    logic [1:0]   f;
    logic [127:0] d;
    logic [127:0] ek;
    logic         ekv;
    cnt = 0; f = 2'd0; d = '0; ek = '0; ekv = 1'b0;
    forever begin
      @(negedge clk);
      bus.core_ready = 1'b0;
      if (!rst) begin
        cnt = 0;
        ekv = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.core_ready  = 1'b1;
            bus.core_result = coreCompute(f, d, ek, ekv);
            if (f == 2'd1) begin
              ek  = d;
              ekv = 1'b1;
            end
          end
        end
        if (bus.core_enable) begin
          f   = bus.core_func;
          d   = bus.core_data;
          cnt = core_lat;
          core_log.push_back({f, d});
        end
      end
    end
  endtask

  // Monitor. It pops expected grants and responses, checks them and measures latency.
  task automatic monitorLoop();
    logic [NREQ-1:0] oh;
    exp_t            e;
    int              gp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        outstanding = 0;
      end else begin
        if (bus.req_ready != '0) begin
          checkOutput("grant outstanding", 130'(outstanding), 130'(0));
          if (gnt_q.size() == 0) failNow("unexpected req_ready");
          else begin
            gp = gnt_q.pop_front();
            oh = '0;
            oh[gp] = 1'b1;
            checkOutput("grant port", 130'(bus.req_ready), 130'(oh));
            grant_cycle[gp] = cyc;
          end
          outstanding++;
        end
        if (bus.rsp_valid != '0) begin
          if (sb_q.size() == 0) failNow("unexpected rsp_valid");
          else begin
            e = sb_q.pop_front();
            oh = '0;
            oh[e.port] = 1'b1;
            checkOutput("rsp port", 130'(bus.rsp_valid), 130'(oh));
            checkOutput("rsp data", 130'(bus.rsp_data), 130'(e.data));
            checkOutput("rsp err", 130'(bus.rsp_err), 130'(e.err));
            if (e.lat > 0) checkOutput("rsp latency", 130'(cyc - grant_cycle[e.port]), 130'(e.lat));
          end
          outstanding--;
        end
      end
    end
  endtask

  // Drive one request on a port, wait up to a bounded time for its grant, then drop valid.
  task automatic applyStimulus(input int p, input logic [1:0] f, input logic [127:0] k, input logic [127:0] d);
    bit got;
    got = 1'b0;
    p_func[p]  = f;
    p_key[p]   = k;
    p_data[p]  = d;
    p_valid[p] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.req_ready[p]) begin
        got = 1'b1;
        break;
      end
    end
    p_valid[p] = 1'b0;
    if (!got) failNow($sformatf("grant timeout port %0d", p));
  endtask

  task automatic portThread(input int p, input logic [1:0] f, input logic [127:0] d);
    for (int r = 0; r < 2; r++) applyStimulus(p, f, KEY, d);
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 800; i++) begin
      if (sb_q.size() == 0 && gnt_q.size() == 0) break;
      @(negedge clk);
    end
    checkOutput(name, 130'(sb_q.size() + gnt_q.size()), 130'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic checkLog(input string name, input int idx, input logic [1:0] f, input logic [127:0] d);
    if (idx < core_log.size()) checkOutput(name, core_log[idx], {f, d});
    else failNow($sformatf("%s: core op %0d missing", name, idx));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " req_ready"},   130'(bus.req_ready), 130'(0));
    checkOutput({tag, " rsp_valid"},   130'(bus.rsp_valid), 130'(0));
    checkOutput({tag, " rsp_data"},    130'(bus.rsp_data), 130'(0));
    checkOutput({tag, " rsp_err"},     130'(bus.rsp_err), 130'(0));
    checkOutput({tag, " core_enable"}, 130'(bus.core_enable), 130'(0));
    checkOutput({tag, " core_func"},   130'(bus.core_func), 130'(0));
    checkOutput({tag, " core_data"},   130'(bus.core_data), 130'(0));
    checkOutput({tag, " busy"},        130'(busy), 130'(0));
  endtask

  // Directed test sequence. The monitor, core model and watchdog run as forked threads.
  initial begin
    checks = 0; passes = 0; outstanding = 0; core_lat = 2;
    for (int p = 0; p < NREQ; p++) begin
      p_valid[p] = 1'b0; p_func[p] = 2'd0; p_key[p] = '0; p_data[p] = '0; grant_cycle[p] = 0;
    end
    bus.core_ready  = 1'b0;
    bus.core_result = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 checkResetOutputs("reset");
    fork
      monitorLoop();
      coreLoop();
      begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
      end
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] cold-cache cipher on port 0");
    core_lat = 2;
    core_log.delete();
    queueExpect(0, CT, 1'b0, 10);
    applyStimulus(0, 2'd2, KEY, PT);
    waitDone("cold cipher drained");
    checkOutput("cold cipher op count", 130'(core_log.size()), 130'(2));
    checkLog("cold cipher kexp", 0, 2'd1, KEY);
    checkLog("cold cipher data", 1, 2'd2, PT);

    $display("[TB] cached cipher on port 0");
    core_log.delete();
    queueExpect(0, CT, 1'b0, 6);
    applyStimulus(0, 2'd2, KEY, PT);
    waitDone("cached cipher drained");
    checkOutput("cached cipher op count", 130'(core_log.size()), 130'(1));
    checkLog("cached cipher data", 0, 2'd2, PT);

    $display("[TB] cached icipher on port 1");
    core_log.delete();
    queueExpect(1, PT, 1'b0, 6);
    applyStimulus(1, 2'd3, KEY, CT);
    waitDone("icipher drained");
    checkOutput("icipher op count", 130'(core_log.size()), 130'(1));
    checkLog("icipher data", 0, 2'd3, CT);

    $display("[TB] all ports requesting after reset");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    core_lat = 1;
    core_log.delete();
    for (int k = 0; k < 8; k++)
      queueExpect(k % 4, ((k % 2) == 0) ? CT : PT, 1'b0, (k == 0) ? 8 : 5);
    fork
      portThread(0, 2'd2, PT);
      portThread(1, 2'd3, CT);
      portThread(2, 2'd2, PT);
      portThread(3, 2'd3, CT);
    join
    waitDone("round robin drained");
    checkOutput("round robin op count", 130'(core_log.size()), 130'(9));
    checkLog("round robin kexp", 0, 2'd1, KEY);

    $display("[TB] func 0 on port 2");
    core_log.delete();
    queueExpect(2, '0, 1'b1, 2);
    applyStimulus(2, 2'd0, KEY, PT);
    waitDone("func0 drained");
    checkOutput("func0 op count", 130'(core_log.size()), 130'(0));

    $display("[TB] reset during data wait");
    core_lat = 4;
    core_log.delete();
    gnt_q.push_back(0);
    applyStimulus(0, 2'd2, KEY, PT);
    for (int i = 0; i < 50; i++) begin
      if (core_log.size() > 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("abort core op seen", 130'(core_log.size()), 130'(1));
    #2 rst = 1'b0;
    #1 checkResetOutputs("mid-cycle reset");
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("abort no grant pending", 130'(gnt_q.size()), 130'(0));
    core_log.delete();
    queueExpect(0, CT, 1'b0, 14);
    applyStimulus(0, 2'd2, KEY, PT);
    waitDone("post-abort drained");
    checkOutput("post-abort op count", 130'(core_log.size()), 130'(2));
    checkLog("post-abort kexp", 0, 2'd1, KEY);
    checkLog("post-abort data", 1, 2'd2, PT);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
